camera_init_release_ctrl: RTL
=============================

# camera_init_release_ctrl

Sits directly downstream of the camera power-on sequencer. Watches the sequenced XCLR release and the three rail power-good signals, enforces the sensor standby-release wait, then hands off to the SPI register-init engine through a req/ack/done handshake. It retries on init timeout, declares a sticky fault on rail loss or retry exhaustion, and tells the NIOS II subsystem when the camera is ready for streaming.

## Interface
Parameters:
- STANDBY_CYCLES, 32'd20000: dwell after XCLR release and power-good before init is requested (ctrl_clk_i cycles).
- INIT_TIMEOUT, 32'd1000000: maximum cycles from REQ entry to init_done_i.
- MAX_RETRY, 4'd3: init retries allowed after the first attempt before FAULT.

Ports (one clock; reset asynchronous, active-high):
- ctrl_clk_i, in, 1: control clock.
- ctrl_rst_i, in, 1: asynchronous active-high reset.
- xclr_i, in, 1: sensor XCLR from the power-on sequencer, synchronous to ctrl_clk_i.
- pg_1v2_i / pg_1v8_i / pg_3v3_i, in, 1 each: regulator power-good, asynchronous.
- init_ack_i, in, 1: init engine accepted the request.
- init_done_i, in, 1: single-cycle pulse, register init complete.
- clear_fault_i, in, 1: single-cycle pulse, leave FAULT.
- init_req_o, out, 1: init request, level.
- cam_ready_o, out, 1: camera configured and ready.
- fault_o, out, 1: sticky fault.
- fault_code_o, out, 2: 00 none, 01 rail loss, 10 init timeout exhausted.
- retry_count_o, out, 4: retries consumed in the current power cycle.
- state_o, out, 3: current state encoding, for debug.

## Operation
- Each pg_*_i passes through a 2-flop synchronizer. pg_all = AND of the synchronized values.
- States and encodings: WAIT_PWR 0, SETTLE 1, REQ 2, BUSY 3, READY 4, FAULT 5. Reset enters WAIT_PWR.
- WAIT_PWR -> SETTLE when xclr_i & pg_all. Entry clears the 32-bit counter.
- SETTLE -> REQ when counter == STANDBY_CYCLES-1, giving exactly STANDBY_CYCLES cycles in SETTLE. Entry clears the counter.
- REQ: init_req_o = 1. Move to BUSY on the first cycle init_ack_i = 1.
- The counter runs through REQ and BUSY.
- BUSY -> READY on init_done_i.
- Timeout: counter == INIT_TIMEOUT-1 in REQ or BUSY without done.
  - If retry_count < MAX_RETRY: increment retry_count, go to SETTLE.
  - Otherwise: go to FAULT, code 10.
- READY: cam_ready_o = 1. init_done_i is ignored.
- Every state except WAIT_PWR and FAULT obeys these, in priority order:
  - xclr_i = 0: go to WAIT_PWR, clear retry_count. This is a normal power-down.
  - pg_all = 0 while xclr_i = 1: go to FAULT, code 01.
  - init_done_i, then timeout.
- FAULT: fault_o = 1, code held. Exit only on clear_fault_i, to WAIT_PWR, which clears the code and retry_count. clear_fault_i outside FAULT is ignored.
- The counter saturates; it never wraps.

## Timing
- Reset values: init_req_o 0, cam_ready_o 0, fault_o 0, fault_code_o 00, retry_count_o 0, state_o 0. Synchronizers reset to 0.
- All outputs are registered and loaded from next-state logic, so they change on the same edge as state_o.
- A pg deassertion reaches the FSM 2 cycles after the pin changes. fault_o rises on the following edge, 3 edges total.
- xclr_i is not synchronized: from xclr_i sampled high with pg_all already high, SETTLE is entered on that edge.
- init_ack_i and init_done_i high in the same REQ cycle: go to BUSY. The done is lost and the timeout path covers it.
- Asserting reset mid-operation drops init_req_o and cam_ready_o immediately (asynchronously).

## Structure
- Shared package `camera_ctrl_pkg`: state encodings, fault codes, and default STANDBY/TIMEOUT constants.
- One sub-module, `pg_sync2`: a parameterized-width 2-flop synchronizer, instantiated once with width 3.
- FSM and counter live in the top module.

## Test plan
Bench uses STANDBY_CYCLES=10, INIT_TIMEOUT=50, MAX_RETRY=2.
1. pg all high, xclr rises at cycle 0:
   - init_req_o rises exactly 10 cycles after SETTLE entry.
   - ack at +3, done at +8: cam_ready_o = 1, retry_count_o = 0.
2. Ack given, done never arrives:
   - init_req_o re-asserts after each 50-cycle window plus 10 settle cycles.
   - After the third timeout: fault_o = 1, fault_code_o = 10, retry_count_o = 2.
3. In READY, drop pg_1v8_i:
   - fault_o = 1, code 01, cam_ready_o = 0 three edges later.
   - clear_fault_i then returns to state_o = 0.
4. In BUSY, drop xclr_i:
   - state_o = 0, init_req_o = 0, retry_count_o = 0, no fault.
   - Re-raising xclr_i restarts SETTLE.
5. In BUSY, pg loss and init_done_i on the same synchronized cycle: FAULT, code 01 (priority check).
6. Assert ctrl_rst_i mid-REQ, unaligned to the clock: all outputs reach reset values without a clock edge, and state_o = 0 after release.

Source files
------------

// File: rtl/camera_ctrl_pkg.sv
// Shared definitions for the camera init-release controller.
//   cam_state_e  : FSM state encodings, also driven out on state_o for debug
//   fault_code_e : sticky fault reason reported on fault_code_o
//   DEF_*        : default timing and retry parameters
package camera_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_PWR = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_REQ      = 3'd2,
    ST_BUSY     = 3'd3,
    ST_READY    = 3'd4,
    ST_FAULT    = 3'd5
  } cam_state_e;

  typedef enum logic [1:0] {
    FC_NONE      = 2'b00,
    FC_RAIL_LOSS = 2'b01,
    FC_INIT_TMO  = 2'b10
  } fault_code_e;

  localparam logic [31:0] DEF_STANDBY_CYCLES = 32'd20000;
  localparam logic [31:0] DEF_INIT_TIMEOUT   = 32'd1000000;
  localparam logic [3:0]  DEF_MAX_RETRY      = 4'd3;

endpackage

// File: rtl/pg_sync2.sv
// Two-flop synchronizer for a bus of independent asynchronous level signals.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, clears both stages
//   d_i   : asynchronous inputs
//   q_o   : synchronized outputs, two clk_i edges of latency
module pg_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/camera_init_release_ctrl.sv
// Camera init-release controller: waits for XCLR release and all rails good,
// dwells for the sensor standby-release time, requests SPI register init via
// req/ack/done, retries on init timeout and latches a sticky fault on rail
// loss or retry exhaustion.
//   ctrl_clk_i, ctrl_rst_i        : clock, async active-high reset
//   xclr_i                        : sequenced XCLR (already synchronous)
//   pg_1v2_i, pg_1v8_i, pg_3v3_i  : asynchronous rail power-good
//   init_ack_i, init_done_i       : init engine handshake
//   clear_fault_i                 : pulse, leave FAULT
//   init_req_o, cam_ready_o, fault_o, fault_code_o, retry_count_o, state_o
//                                 : registered status outputs
//
// state    | meaning
// WAIT_PWR | waiting for XCLR high and all rails good
// SETTLE   | standby-release dwell of STANDBY_CYCLES
// REQ      | init_req_o high, waiting for ack
// BUSY     | init accepted, waiting for done
// READY    | camera configured, cam_ready_o high
// FAULT    | sticky fault until clear_fault_i
module camera_init_release_ctrl
  import camera_ctrl_pkg::*;
#(
  parameter logic [31:0] STANDBY_CYCLES = DEF_STANDBY_CYCLES,
  parameter logic [31:0] INIT_TIMEOUT   = DEF_INIT_TIMEOUT,
  parameter logic [3:0]  MAX_RETRY      = DEF_MAX_RETRY
) (
  input  logic       ctrl_clk_i,
  input  logic       ctrl_rst_i,
  input  logic       xclr_i,
  input  logic       pg_1v2_i,
  input  logic       pg_1v8_i,
  input  logic       pg_3v3_i,
  input  logic       init_ack_i,
  input  logic       init_done_i,
  input  logic       clear_fault_i,
  output logic       init_req_o,
  output logic       cam_ready_o,
  output logic       fault_o,
  output logic [1:0] fault_code_o,
  output logic [3:0] retry_count_o,
  output logic [2:0] state_o
);

  logic [2:0]  pg_sync;
  logic        pg_all;

  cam_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  fault_code_e fcode_q, fcode_d;
  logic        init_req_q, init_req_d;
  logic        cam_ready_q, cam_ready_d;
  logic        fault_q, fault_d;

  logic        settle_done;
  logic        init_tmo;
  cam_state_e  tmo_state;
  logic [3:0]  tmo_retry;
  fault_code_e tmo_fcode;

  pg_sync2 #(.WIDTH(3)) u_pg_sync (
    .clk_i (ctrl_clk_i),
    .rst_i (ctrl_rst_i),
    .d_i   ({pg_3v3_i, pg_1v8_i, pg_1v2_i}),
    .q_o   (pg_sync)
  );

  assign pg_all      = &pg_sync;
  assign settle_done = (cnt_q == STANDBY_CYCLES - 32'd1);
  assign init_tmo    = (cnt_q == INIT_TIMEOUT - 32'd1);

  // Outcome of an init timeout: another settle/request round, or give up.
  always_comb begin
    tmo_state = ST_FAULT;
    tmo_retry = retry_q;
    tmo_fcode = FC_INIT_TMO;
    if (retry_q < MAX_RETRY) begin
      tmo_state = ST_SETTLE;
      tmo_retry = retry_q + 4'd1;
      tmo_fcode = fcode_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    retry_d = retry_q;
    fcode_d = fcode_q;

    case (state_q)
      ST_WAIT_PWR: begin
        if (xclr_i && pg_all) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_FAULT: begin
        if (clear_fault_i) begin
          state_d = ST_WAIT_PWR;
          fcode_d = FC_NONE;
          retry_d = '0;
        end
      end
      ST_SETTLE, ST_REQ, ST_BUSY, ST_READY: begin
        if (!xclr_i) begin
          state_d = ST_WAIT_PWR;
          retry_d = '0;
        end else if (!pg_all) begin
          state_d = ST_FAULT;
          fcode_d = FC_RAIL_LOSS;
        end else begin
          case (state_q)
            ST_SETTLE: begin
              if (settle_done) begin
                state_d = ST_REQ;
                cnt_d   = '0;
              end
            end
            // Timeout wins over a late ack so the counter can never pass the
            // terminal count unnoticed in BUSY.
            ST_REQ: begin
              if (init_tmo) begin
                state_d = tmo_state;
                retry_d = tmo_retry;
                fcode_d = tmo_fcode;
                cnt_d   = '0;
              end else if (init_ack_i) begin
                state_d = ST_BUSY;
              end
            end
            ST_BUSY: begin
              if (init_done_i) begin
                state_d = ST_READY;
              end else if (init_tmo) begin
                state_d = tmo_state;
                retry_d = tmo_retry;
                fcode_d = tmo_fcode;
                cnt_d   = '0;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_WAIT_PWR;
    endcase

    init_req_d  = (state_d == ST_REQ);
    cam_ready_d = (state_d == ST_READY);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge ctrl_clk_i or posedge ctrl_rst_i) begin
    if (ctrl_rst_i) begin
      state_q     <= ST_WAIT_PWR;
      cnt_q       <= '0;
      retry_q     <= '0;
      fcode_q     <= FC_NONE;
      init_req_q  <= 1'b0;
      cam_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      fcode_q     <= fcode_d;
      init_req_q  <= init_req_d;
      cam_ready_q <= cam_ready_d;
      fault_q     <= fault_d;
    end
  end

  assign init_req_o    = init_req_q;
  assign cam_ready_o   = cam_ready_q;
  assign fault_o       = fault_q;
  assign fault_code_o  = fcode_q;
  assign retry_count_o = retry_q;
  assign state_o       = state_q;

endmodule
